intcon_ctrl: RTL and testbench

INTCON_CTRL -- requirements
Module: intcon_ctrl

---
 rtl/intcon_pkg.sv | 28 ++
 rtl/sync_edge.sv | 47 ++++
 rtl/intcon_ctrl.sv | 139 +++++++++++++
 tb/tb_intcon_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intcon_pkg.sv
// INTCON bit positions, reset value and the shared pending-interrupt term.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package intcon_pkg;

  // INTCON layout: {GIE,EEIE,T0IE,INTE,RBIE,T0IF,INTF,RBIF}
  localparam int GIE_B  = 7;
  localparam int EEIE_B = 6;
  localparam int T0IE_B = 5;
  localparam int INTE_B = 4;
  localparam int RBIE_B = 3;
  localparam int T0IF_B = 2;
  localparam int INTF_B = 1;
  localparam int RBIF_B = 0;

  localparam logic [7:0] INTCON_RST = 8'h00;

  // Any enabled source pending; GIE is applied by the caller so the same
  // term serves both irq and wake.
  function automatic logic int_pending(input logic [7:0] r, input logic eelat);
    logic [2:0] en;
    logic [2:0] fl;
    en = {r[T0IE_B], r[INTE_B], r[RBIE_B]};
    fl = {r[T0IF_B], r[INTF_B], r[RBIF_B]};
    return (|(en & fl)) | (r[EEIE_B] & eelat);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with rise/fall detection for one asynchronous pin.
// Latency: a pin change shows up on rise_o/fall_o two clocks after it is first sampled.
// Backpressure: none; ports: clk, rst_n (sync, active-low), din -> sync_o, vld_o, rise_o, fall_o.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync_o,
  output logic vld_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;
  logic [2:0] fill_q, fill_d;

  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    prev_d = s2_q;
    // Marks which stages hold real pin samples since reset release, so the
    // cleared reset values are never mistaken for a pin edge.
    fill_d = {fill_q[1:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
      fill_q <= 3'b000;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      fill_q <= fill_d;
    end
  end

  assign sync_o = s2_q;
  assign vld_o  = fill_q[2];
  assign rise_o = fill_q[2] &  s2_q & ~prev_q;
  assign fall_o = fill_q[2] & ~s2_q &  prev_q;

endmodule

// File: rtl/intcon_ctrl.sv
// INTCON interrupt controller: flag capture, enables, GIE handling, irq/wake generation.
// Latency: T0IF one clock after the t0if_in rise is sampled, INTF/RBIF three clocks after a pin change; irq/wake combinational from state.
// Backpressure: none. Macro INTCON_RBCHG_EN enables RB7:RB4 port-change logic (RBIF); otherwise rb_hi is ignored and RBIF reads 0.
// Ports: oscIn clock, mclr_n sync active-low reset, t0if_in/int_pin/intedg/rb_hi/eeif_in event sources,
//        intcon_we/intcon_wdata CPU write, irq_ack/retfie core pulses, intcon_out/irq/wake outputs.
module intcon_ctrl
  import intcon_pkg::*;
(
  input  logic       oscIn,
  input  logic       mclr_n,
  input  logic       t0if_in,
  input  logic       int_pin,
  input  logic       intedg,
  input  logic [3:0] rb_hi,
  input  logic       eeif_in,
  input  logic       intcon_we,
  input  logic [7:0] intcon_wdata,
  input  logic       irq_ack,
  input  logic       retfie,
  output logic [7:0] intcon_out,
  output logic       irq,
  output logic       wake
);

  logic [7:0] intcon_q, intcon_d;
  logic       eelat_q, eelat_d;
  logic       t0_prev_q, t0_prev_d;
  logic       t0_arm_q, t0_arm_d;
  logic       t0_rise;
  logic       int_set;
  logic       pend;

  // External INT pin
  logic int_sync, int_vld, int_rise, int_fall;
  logic unused_int;

  sync_edge u_int_sync (
    .clk    (oscIn),
    .rst_n  (mclr_n),
    .din    (int_pin),
    .sync_o (int_sync),
    .vld_o  (int_vld),
    .rise_o (int_rise),
    .fall_o (int_fall)
  );

  assign unused_int = int_sync ^ int_vld;

`ifdef INTCON_RBCHG_EN
  // RB7:RB4 port change
  logic [3:0] rb_sync, rb_vld, rb_rise, rb_fall;
  logic [3:0] rb_lat_q, rb_lat_d;
  logic       rb_all_vld;
  logic       rbif_set;
  logic       unused_rb_edges;

  for (genvar i = 0; i < 4; i++) begin : g_rb
    sync_edge u_rb_sync (
      .clk    (oscIn),
      .rst_n  (mclr_n),
      .din    (rb_hi[i]),
      .sync_o (rb_sync[i]),
      .vld_o  (rb_vld[i]),
      .rise_o (rb_rise[i]),
      .fall_o (rb_fall[i])
    );
  end

  assign rb_all_vld      = &rb_vld;
  assign unused_rb_edges = ^{rb_rise, rb_fall};

  always_comb begin
    // Until the synchronizers hold real samples the latch just tracks them,
    // so pin levels present at reset release do not count as a change.
    rb_lat_d = (intcon_we || !rb_all_vld) ? rb_sync : rb_lat_q;
    rbif_set = rb_all_vld && (rb_sync != rb_lat_q);
  end

  always_ff @(posedge oscIn) begin
    if (!mclr_n) begin
      rb_lat_q <= 4'h0;
    end else begin
      rb_lat_q <= rb_lat_d;
    end
  end
`else
  logic unused_rb;
  assign unused_rb = ^rb_hi;
`endif

  always_comb begin
    // t0_arm_q keeps a t0if_in that is already high at reset release from
    // looking like a fresh rise.
    t0_rise   = t0_arm_q & t0if_in & ~t0_prev_q;
    t0_prev_d = t0if_in;
    t0_arm_d  = 1'b1;
    int_set   = intedg ? int_rise : int_fall;

    intcon_d = intcon_q;
    if (intcon_we) begin
      intcon_d = intcon_wdata;
    end else if (retfie) begin
      intcon_d[GIE_B] = 1'b1;
    end else if (irq_ack) begin
      intcon_d[GIE_B] = 1'b0;
    end

    // Hardware sets are ORed in after the write so a simultaneous set wins.
    intcon_d[T0IF_B] = intcon_d[T0IF_B] | t0_rise;
    intcon_d[INTF_B] = intcon_d[INTF_B] | int_set;
`ifdef INTCON_RBCHG_EN
    intcon_d[RBIF_B] = intcon_d[RBIF_B] | rbif_set;
`else
    intcon_d[RBIF_B] = 1'b0;
`endif

    eelat_d = eeif_in | (eelat_q & ~(intcon_we & ~intcon_wdata[EEIE_B]));
  end

  always_ff @(posedge oscIn) begin
    if (!mclr_n) begin
      intcon_q  <= INTCON_RST;
      eelat_q   <= 1'b0;
      t0_prev_q <= 1'b0;
      t0_arm_q  <= 1'b0;
    end else begin
      intcon_q  <= intcon_d;
      eelat_q   <= eelat_d;
      t0_prev_q <= t0_prev_d;
      t0_arm_q  <= t0_arm_d;
    end
  end

  assign pend       = int_pending(intcon_q, eelat_q);
  assign irq        = intcon_q[GIE_B] & pend;
  assign wake       = pend;
  assign intcon_out = intcon_q;

endmodule

// File: tb/tb_intcon_ctrl.sv
// Self-checking bench for intcon_ctrl: directed scenarios plus a randomized run against a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_intcon_ctrl;

`ifdef INTCON_RBCHG_EN
  localparam bit RBCHG = 1'b1;
`else
  localparam bit RBCHG = 1'b0;
`endif

  logic       oscIn;
  logic       mclr_n;
  logic       t0if_in;
  logic       int_pin;
  logic       intedg;
  logic [3:0] rb_hi;
  logic       eeif_in;
  logic       intcon_we;
  logic [7:0] intcon_wdata;
  logic       irq_ack;
  logic       retfie;
  logic [7:0] intcon_out;
  logic       irq;
  logic       wake;

  int n_run  = 0;
  int n_fail = 0;

  intcon_ctrl dut (
    .oscIn        (oscIn),
    .mclr_n       (mclr_n),
    .t0if_in      (t0if_in),
    .int_pin      (int_pin),
    .intedg       (intedg),
    .rb_hi        (rb_hi),
    .eeif_in      (eeif_in),
    .intcon_we    (intcon_we),
    .intcon_wdata (intcon_wdata),
    .irq_ack      (irq_ack),
    .retfie       (retfie),
    .intcon_out   (intcon_out),
    .irq          (irq),
    .wake         (wake)
  );

  initial oscIn = 1'b0;
  always #5 oscIn = ~oscIn;

  // Reference model: register image plus raw pin-sample histories since reset.
  // An asynchronous pin is seen through a two-sample delay; an edge counts once
  // three post-reset samples exist.
  logic [7:0] m_intcon = 8'h00;
  bit         m_eel    = 1'b0;
  bit         m_t0prev = 1'b0;
  bit         m_t0arm  = 1'b0;
  logic [3:0] m_rblat  = 4'h0;
  bit         q_int[$];
  logic [3:0] q_rb[$];

  function automatic bit m_pend();
    return (|({m_intcon[5], m_intcon[4], m_intcon[3]} & {m_intcon[2], m_intcon[1], m_intcon[0]}))
           | (m_intcon[6] & m_eel);
  endfunction

  function automatic bit m_irq();
    return m_intcon[7] & m_pend();
  endfunction

  task automatic model_step();
    logic [7:0] nx;
    bit         t0r, intr, rbr, rv, nw, od;
    logic [3:0] rs;
    int         n;
    if (!mclr_n) begin
      m_intcon = 8'h00;
      m_eel    = 1'b0;
      m_t0prev = 1'b0;
      m_t0arm  = 1'b0;
      m_rblat  = 4'h0;
      q_int.delete();
      q_rb.delete();
    end else begin
      t0r = m_t0arm && t0if_in && !m_t0prev;
      intr = 1'b0;
      n = q_int.size();
      if (n >= 3) begin
        nw = q_int[n-2];
        od = q_int[n-3];
        intr = intedg ? (nw && !od) : (!nw && od);
      end
      n  = q_rb.size();
      rs = (n >= 2) ? q_rb[n-2] : 4'h0;
      rv = (n >= 3);
      rbr = RBCHG && rv && (rs != m_rblat);
      if (intcon_we || !rv) m_rblat = rs;

      nx = m_intcon;
      if (intcon_we) nx = intcon_wdata;
      else if (retfie) nx[7] = 1'b1;
      else if (irq_ack) nx[7] = 1'b0;
      nx[2] = nx[2] | t0r;
      nx[1] = nx[1] | intr;
      nx[0] = RBCHG ? (nx[0] | rbr) : 1'b0;
      m_intcon = nx;

      m_eel = eeif_in || (m_eel && !(intcon_we && !intcon_wdata[6]));
      m_t0prev = t0if_in;
      m_t0arm  = 1'b1;
      q_int.push_back(int_pin);
      if (q_int.size() > 3) void'(q_int.pop_front());
      q_rb.push_back(rb_hi);
      if (q_rb.size() > 3) void'(q_rb.pop_front());
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge oscIn);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    intcon_we    = 1'b1;
    intcon_wdata = d;
    tick();
    intcon_we    = 1'b0;
  endtask

  task automatic test_reset();
    mclr_n = 1'b0;
    tick();
    tick();
    n_run++;
    if ({intcon_out, irq, wake} !== {8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: intcon/irq/wake=%h/%b/%b want 00/0/0", intcon_out, irq, wake);
    end
    mclr_n = 1'b1;
  endtask

  task automatic test_t0();
    wr(8'hA0);
    t0if_in = 1'b1;
    tick();
    n_run++;
    if ({intcon_out, irq} !== {8'hA4, 1'b1}) begin
      n_fail++;
      $display("FAIL t0_set: intcon/irq=%h/%b want a4/1", intcon_out, irq);
    end
    wr(8'hA0);
    tick();
    n_run++;
    if ({intcon_out, irq} !== {8'hA0, 1'b0}) begin
      n_fail++;
      $display("FAIL t0_once: intcon/irq=%h/%b want a0/0", intcon_out, irq);
    end
    t0if_in = 1'b0;
    tick();
  endtask

  task automatic test_set_wins();
    intcon_we    = 1'b1;
    intcon_wdata = 8'h20;
    t0if_in      = 1'b1;
    tick();
    intcon_we = 1'b0;
    t0if_in   = 1'b0;
    n_run++;
    if (intcon_out !== 8'h24) begin
      n_fail++;
      $display("FAIL set_wins: intcon=%h want 24", intcon_out);
    end
    tick();
  endtask

  task automatic test_int_edge();
    intedg  = 1'b0;
    int_pin = 1'b1;
    repeat (4) tick();
    wr(8'h90);
    int_pin = 1'b0;
    tick();
    tick();
    n_run++;
    if (intcon_out[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL int_early: intf=%b want 0", intcon_out[1]);
    end
    tick();
    n_run++;
    if ({intcon_out, irq} !== {8'h92, 1'b1}) begin
      n_fail++;
      $display("FAIL int_fall: intcon/irq=%h/%b want 92/1", intcon_out, irq);
    end
    wr(8'h90);
    int_pin = 1'b1;
    repeat (5) tick();
    n_run++;
    if (intcon_out !== 8'h90) begin
      n_fail++;
      $display("FAIL int_rise_ignored: intcon=%h want 90", intcon_out);
    end
    intedg = 1'b1;
    repeat (4) tick();
    n_run++;
    if (intcon_out !== 8'h90) begin
      n_fail++;
      $display("FAIL intedg_change: intcon=%h want 90", intcon_out);
    end
  endtask

  task automatic test_ack_retfie();
    wr(8'h92);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    n_run++;
    if ({intcon_out, irq, wake} !== {8'h12, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL irq_ack: intcon/irq/wake=%h/%b/%b want 12/0/1", intcon_out, irq, wake);
    end
    retfie = 1'b1;
    tick();
    retfie = 1'b0;
    n_run++;
    if ({intcon_out, irq} !== {8'h92, 1'b1}) begin
      n_fail++;
      $display("FAIL retfie: intcon/irq=%h/%b want 92/1", intcon_out, irq);
    end
    irq_ack = 1'b1;
    retfie  = 1'b1;
    tick();
    irq_ack = 1'b0;
    n_run++;
    if (intcon_out !== 8'h92) begin
      n_fail++;
      $display("FAIL ack_with_retfie: intcon=%h want 92", intcon_out);
    end
    wr(8'h12);
    retfie = 1'b0;
    n_run++;
    if (intcon_out !== 8'h12) begin
      n_fail++;
      $display("FAIL we_over_retfie: intcon=%h want 12", intcon_out);
    end
  endtask

  task automatic test_eeif();
    wr(8'h40);
    eeif_in = 1'b1;
    tick();
    eeif_in = 1'b0;
    n_run++;
    if ({intcon_out, irq, wake} !== {8'h40, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL eeif_wake: intcon/irq/wake=%h/%b/%b want 40/0/1", intcon_out, irq, wake);
    end
    wr(8'hC0);
    n_run++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL eeif_irq: irq=%b want 1", irq);
    end
    wr(8'h80);
    wr(8'hC0);
    n_run++;
    if ({irq, wake} !== 2'b00) begin
      n_fail++;
      $display("FAIL eeif_clear: irq/wake=%b/%b want 0/0", irq, wake);
    end
  endtask

  task automatic test_rbchg();
    logic [7:0] exp;
    wr(8'h88);
    rb_hi = 4'h8;
    tick();
    tick();
    n_run++;
    if (intcon_out !== 8'h88) begin
      n_fail++;
      $display("FAIL rb_early: intcon=%h want 88", intcon_out);
    end
    tick();
    exp = RBCHG ? 8'h89 : 8'h88;
    n_run++;
    if ({intcon_out, irq} !== {exp, RBCHG}) begin
      n_fail++;
      $display("FAIL rb_change: intcon/irq=%h/%b want %h/%b", intcon_out, irq, exp, RBCHG);
    end
    rb_hi = 4'h0;
    repeat (4) tick();
    wr(8'h88);
    n_run++;
    if (intcon_out !== 8'h88) begin
      n_fail++;
      $display("FAIL rb_clear: intcon=%h want 88", intcon_out);
    end
    wr(8'h89);
    n_run++;
    if (intcon_out !== exp) begin
      n_fail++;
      $display("FAIL rb_sw_set: intcon=%h want %h", intcon_out, exp);
    end
    wr(8'h00);
  endtask

  task automatic test_reset_mid();
    intedg = 1'b0;
    repeat (4) tick();
    wr(8'h90);
    int_pin = 1'b0;
    t0if_in = 1'b1;
    tick();
    mclr_n = 1'b0;
    tick();
    n_run++;
    if ({intcon_out, irq, wake} !== {8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid: intcon/irq/wake=%h/%b/%b want 00/0/0", intcon_out, irq, wake);
    end
    mclr_n = 1'b1;
    repeat (6) tick();
    n_run++;
    if (intcon_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_pending_fall: intcon=%h want 00", intcon_out);
    end
    intedg  = 1'b1;
    int_pin = 1'b1;
    mclr_n  = 1'b0;
    tick();
    mclr_n = 1'b1;
    repeat (6) tick();
    n_run++;
    if (intcon_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_pending_rise: intcon=%h want 00", intcon_out);
    end
    t0if_in = 1'b0;
    tick();
    t0if_in = 1'b1;
    tick();
    n_run++;
    if (intcon_out !== 8'h04) begin
      n_fail++;
      $display("FAIL t0_after_reset: intcon=%h want 04", intcon_out);
    end
    t0if_in = 1'b0;
    wr(8'h00);
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      mclr_n = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 7) == 0) int_pin = ~int_pin;
      if ($urandom_range(0, 31) == 0) intedg = ~intedg;
      if ($urandom_range(0, 3) == 0) t0if_in = ~t0if_in;
      if ($urandom_range(0, 7) == 0) rb_hi = rb_hi ^ 4'($urandom_range(1, 15));
      eeif_in      = ($urandom_range(0, 15) == 0);
      intcon_we    = ($urandom_range(0, 7) == 0);
      intcon_wdata = 8'($urandom);
      irq_ack      = ($urandom_range(0, 7) == 0);
      retfie       = ($urandom_range(0, 7) == 0);
      tick();
      n_run++;
      if ({intcon_out, irq, wake} !== {m_intcon, m_irq(), m_pend()}) begin
        n_fail++;
        $display("FAIL random cycle %0d: intcon/irq/wake=%h/%b/%b want %h/%b/%b",
                 i, intcon_out, irq, wake, m_intcon, m_irq(), m_pend());
      end
    end
    mclr_n    = 1'b1;
    eeif_in   = 1'b0;
    intcon_we = 1'b0;
    irq_ack   = 1'b0;
    retfie    = 1'b0;
  endtask

  initial begin
    mclr_n       = 1'b0;
    t0if_in      = 1'b0;
    int_pin      = 1'b0;
    intedg       = 1'b0;
    rb_hi        = 4'h0;
    eeif_in      = 1'b0;
    intcon_we    = 1'b0;
    intcon_wdata = 8'h00;
    irq_ack      = 1'b0;
    retfie       = 1'b0;
    #2;
    test_reset();
    test_t0();
    test_set_wins();
    test_int_edge();
    test_ack_retfie();
    test_eeif();
    test_rbchg();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
